// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, their cent values and the
// change-dispenser state encoding.
package vend_pkg;

  typedef enum logic [2:0] {
    NICKEL  = 3'd0,
    DIME    = 3'd1,
    QUARTER = 3'd2,
    FIFTY   = 3'd3,
    DOLLAR  = 3'd4,
    FIVE    = 3'd5
  } coin_e;

  localparam int NUM_COINS = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic logic [31:0] coinCents(input logic [2:0] code);
    case (code)
      3'd0:    return 32'd5;
      3'd1:    return 32'd10;
      3'd2:    return 32'd25;
      3'd3:    return 32'd50;
      3'd4:    return 32'd100;
      3'd5:    return 32'd500;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Picks the largest denomination whose value does not exceed the remaining
// amount. Falls back to NICKEL when nothing fits.
module coin_select
  import vend_pkg::*;
#(
  parameter int AMT_W = 12
) (
  input  logic [AMT_W-1:0] remaining,
  output coin_e            coinCode,
  output logic [AMT_W-1:0] coinValue
);

  logic [NUM_COINS-1:0] fits;

  generate
    for (genvar gi = 0; gi < NUM_COINS; gi++) begin : gFit
      assign fits[gi] = (32'(remaining) >= coinCents(3'(gi)));
    end
  endgenerate

  // Codes ascend with value, so the highest fitting index wins.
  always_comb begin
    coinCode = NICKEL;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (fits[i]) coinCode = coin_e'(i);
    end
    coinValue = AMT_W'(coinCents(coinCode));
  end

endmodule

// File: rtl/change_dispenser.sv
// Converts a change amount into a largest-first sequence of coin release
// handshakes and keeps per-denomination counts for the display.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic             coin_valid,
  output logic [2:0]       coin_type,
  input  logic             coin_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cnt_five,
  output logic [CNT_W-1:0] cnt_dollar,
  output logic [CNT_W-1:0] cnt_fifty,
  output logic [CNT_W-1:0] cnt_quarter,
  output logic [CNT_W-1:0] cnt_dime,
  output logic [CNT_W-1:0] cnt_nickel
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           stateReg;
  logic [AMT_W-1:0] remainingReg;
  logic [AMT_W-1:0] coinValueReg;
  coin_e            coinTypeReg;
  logic             coinValidReg;
  logic             busyReg;
  logic             doneReg;
  logic             errReg;
  logic [CNT_W-1:0] cntReg [NUM_COINS];

  coin_e            selCode;
  logic [AMT_W-1:0] selValue;
  logic             amountOk;

  assign amountOk = ((amount % AMT_W'(5)) == '0);

  coin_select #(
    .AMT_W(AMT_W)
  ) uCoinSelect (
    .remaining(remainingReg),
    .coinCode (selCode),
    .coinValue(selValue)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg     <= IDLE;
      remainingReg <= '0;
      coinValueReg <= '0;
      coinTypeReg  <= NICKEL;
      coinValidReg <= 1'b0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
      errReg       <= 1'b0;
      for (int i = 0; i < NUM_COINS; i++) cntReg[i] <= '0;
    end else begin
      doneReg <= 1'b0;
      errReg  <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (start) begin
            if (amountOk) begin
              remainingReg <= amount;
              busyReg      <= 1'b1;
              stateReg     <= SELECT;
              for (int i = 0; i < NUM_COINS; i++) cntReg[i] <= '0;
            end else begin
              errReg <= 1'b1;
            end
          end
        end
        SELECT: begin
          if (remainingReg == '0) begin
            doneReg  <= 1'b1;
            stateReg <= DONE;
          end else begin
            coinTypeReg  <= selCode;
            coinValueReg <= selValue;
            coinValidReg <= 1'b1;
            stateReg     <= ISSUE;
          end
        end
        ISSUE: begin
          // Selection guarantees coinValueReg <= remainingReg, so no underflow.
          if (coin_ready && coinValidReg) begin
            remainingReg <= remainingReg - coinValueReg;
            if (cntReg[coinTypeReg] != CNT_MAX)
              cntReg[coinTypeReg] <= cntReg[coinTypeReg] + CNT_W'(1);
            coinValidReg <= 1'b0;
            stateReg     <= SELECT;
          end
        end
        DONE: begin
          busyReg  <= 1'b0;
          stateReg <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign coin_valid  = coinValidReg;
  assign coin_type   = coinTypeReg;
  assign busy        = busyReg;
  assign done        = doneReg;
  assign err         = errReg;
  assign cnt_five    = cntReg[FIVE];
  assign cnt_dollar  = cntReg[DOLLAR];
  assign cnt_fifty   = cntReg[FIFTY];
  assign cnt_quarter = cntReg[QUARTER];
  assign cnt_dime    = cntReg[DIME];
  assign cnt_nickel  = cntReg[NICKEL];

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized amounts and
// ready patterns, checked against a greedy-change reference model.
module tb_change_dispenser;

  localparam int AMT_W = 12;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AMT_W-1:0] amount = '0;
  logic             coin_ready = 1'b0;
  logic             coin_valid;
  logic [2:0]       coin_type;
  logic             busy, done, err;
  logic [CNT_W-1:0] cnt_five, cnt_dollar, cnt_fifty, cnt_quarter, cnt_dime, cnt_nickel;

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amount(amount),
    .coin_valid(coin_valid), .coin_type(coin_type), .coin_ready(coin_ready),
    .busy(busy), .done(done), .err(err),
    .cnt_five(cnt_five), .cnt_dollar(cnt_dollar), .cnt_fifty(cnt_fifty),
    .cnt_quarter(cnt_quarter), .cnt_dime(cnt_dime), .cnt_nickel(cnt_nickel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int coinVal [6] = '{5, 10, 25, 50, 100, 500};
  int expQ[$];
  int gotQ[$];
  int expCnt [6];
  int firstValid, doneCyc, badGap, holdBad;
  bit timedOut;
  logic doneAfter, busyAfter;

  // Greedy change: take as many of each coin as fits, largest first.
  function automatic void build_model(input int a);
    int rem;
    rem = a;
    expQ.delete();
    for (int i = 0; i < 6; i++) expCnt[i] = 0;
    for (int c = 5; c >= 0; c--) begin
      while (rem >= coinVal[c]) begin
        expQ.push_back(c);
        expCnt[c]++;
        rem -= coinVal[c];
      end
    end
  endfunction

  function automatic string seq_str(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  function automatic logic [6*CNT_W-1:0] cnt_vec();
    return {cnt_five, cnt_dollar, cnt_fifty, cnt_quarter, cnt_dime, cnt_nickel};
  endfunction

  function automatic logic [6*CNT_W-1:0] exp_vec();
    return {CNT_W'(expCnt[5]), CNT_W'(expCnt[4]), CNT_W'(expCnt[3]),
            CNT_W'(expCnt[2]), CNT_W'(expCnt[1]), CNT_W'(expCnt[0])};
  endfunction

  // Issues one request and records handshakes until done (or a cycle budget).
  // mode 0: ready tied high, 1: random ready, 2: ready low for 5 cycles after first valid.
  task automatic run_request(input int a, input int mode);
    int cyc;
    int lastHs;
    bit prevValid, prevReady;
    logic [2:0] prevType;
    cyc = 0; lastHs = -100; prevValid = 0; prevReady = 0; prevType = '0;
    gotQ.delete();
    firstValid = -1; doneCyc = -1; badGap = 0; holdBad = 0; timedOut = 0;
    @(negedge clk);
    start = 1'b1; amount = AMT_W'(a); coin_ready = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (prevValid && !prevReady && (coin_valid !== 1'b1 || coin_type !== prevType)) holdBad++;
      if (coin_valid === 1'b1 && !prevValid) begin
        if (firstValid < 0) firstValid = cyc;
        else if (cyc - lastHs != 2) badGap++;
      end
      if (done === 1'b1) begin
        doneCyc = cyc;
        break;
      end
      if (cyc > 400) begin
        timedOut = 1;
        break;
      end
      case (mode)
        0: coin_ready = 1'b1;
        1: coin_ready = 1'($urandom_range(0, 1));
        default: coin_ready = (firstValid >= 0 && cyc >= firstValid + 5);
      endcase
      if (coin_valid === 1'b1 && coin_ready) begin
        gotQ.push_back(int'(coin_type));
        lastHs = cyc;
      end
      prevValid = (coin_valid === 1'b1);
      prevReady = coin_ready;
      prevType = coin_type;
    end
    coin_ready = 1'b0;
    @(negedge clk);
    doneAfter = done;
    busyAfter = busy;
    $display("txn amount=%0d mode=%0d coins=[%s] first_valid=%0d done_cycle=%0d",
             a, mode, seq_str(gotQ), firstValid, doneCyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({coin_valid, coin_type, busy, done, err, cnt_vec()} !== '0) begin
      failures++;
      $display("FAIL reset_hold: got valid=%b type=%0d busy=%b done=%b err=%b cnts=%h, want all 0",
               coin_valid, coin_type, busy, done, err, cnt_vec());
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({coin_valid, busy, done, err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_release: got valid=%b busy=%b done=%b err=%b, want 0",
               coin_valid, busy, done, err);
    end
  endtask

  task automatic test_185();
    build_model(185);
    run_request(185, 0);
    checks++;
    if (timedOut || seq_str(gotQ) != seq_str(expQ)) begin
      failures++;
      $display("FAIL seq_185: got [%s] timeout=%0d, want [%s]", seq_str(gotQ), timedOut, seq_str(expQ));
    end
    checks++;
    if (cnt_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL cnt_185: got %h, want %h", cnt_vec(), exp_vec());
    end
    checks++;
    if (firstValid != 2) begin
      failures++;
      $display("FAIL latency_185: first coin_valid at cycle %0d, want 2", firstValid);
    end
    checks++;
    if (badGap != 0) begin
      failures++;
      $display("FAIL gap_185: %0d coins not 2 cycles after handshake, want 0", badGap);
    end
    checks++;
    if (doneAfter !== 1'b0 || busyAfter !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_185: after done got done=%b busy=%b, want 0 0", doneAfter, busyAfter);
    end
  endtask

  task automatic test_1290();
    build_model(1290);
    run_request(1290, 0);
    checks++;
    if (timedOut || seq_str(gotQ) != seq_str(expQ)) begin
      failures++;
      $display("FAIL seq_1290: got [%s] timeout=%0d, want [%s]", seq_str(gotQ), timedOut, seq_str(expQ));
    end
    checks++;
    if (gotQ.size() != 8) begin
      failures++;
      $display("FAIL handshakes_1290: got %0d, want 8", gotQ.size());
    end
    checks++;
    if (cnt_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL cnt_1290: got %h, want %h", cnt_vec(), exp_vec());
    end
  endtask

  task automatic test_bad_amount();
    logic [6*CNT_W-1:0] keep;
    keep = exp_vec();
    @(negedge clk);
    start = 1'b1; amount = AMT_W'(37);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse: got err=%b busy=%b, want 1 0", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || coin_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_width: got err=%b busy=%b valid=%b, want 0 0 0", err, busy, coin_valid);
    end
    checks++;
    if (cnt_vec() !== keep) begin
      failures++;
      $display("FAIL err_counts: got %h, want %h", cnt_vec(), keep);
    end
    $display("txn amount=37 rejected err=1");
  endtask

  task automatic test_zero();
    build_model(0);
    run_request(0, 0);
    checks++;
    if (doneCyc != 2 || firstValid != -1) begin
      failures++;
      $display("FAIL zero_amount: done_cycle=%0d first_valid=%0d, want 2 -1", doneCyc, firstValid);
    end
    checks++;
    if (cnt_vec() !== '0) begin
      failures++;
      $display("FAIL zero_counts: got %h, want 0", cnt_vec());
    end
  endtask

  task automatic test_stall();
    build_model(30);
    run_request(30, 2);
    checks++;
    if (holdBad != 0) begin
      failures++;
      $display("FAIL stall_hold: %0d cycles where valid/type changed while not ready, want 0", holdBad);
    end
    checks++;
    if (timedOut || seq_str(gotQ) != seq_str(expQ) || firstValid != 2) begin
      failures++;
      $display("FAIL stall_seq: got [%s] first=%0d, want [%s] first=2", seq_str(gotQ), firstValid, seq_str(expQ));
    end
    checks++;
    if (cnt_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL stall_cnt: got %h, want %h", cnt_vec(), exp_vec());
    end
  endtask

  task automatic test_midreset();
    bit seen;
    seen = 0;
    @(negedge clk);
    start = 1'b1; amount = AMT_W'(600);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (coin_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL midreset_valid: coin_valid never rose within 10 cycles, want 1");
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (coin_valid !== 1'b0 || busy !== 1'b0 || cnt_vec() !== '0) begin
      failures++;
      $display("FAIL midreset_state: got valid=%b busy=%b cnts=%h, want 0 0 0", coin_valid, busy, cnt_vec());
    end
    rst_n = 1'b1;
    $display("txn amount=600 aborted by reset");
    build_model(5);
    run_request(5, 0);
    checks++;
    if (timedOut || seq_str(gotQ) != seq_str(expQ) || cnt_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL after_reset_5: got [%s] cnts=%h, want [%s] cnts=%h",
               seq_str(gotQ), cnt_vec(), seq_str(expQ), exp_vec());
    end
  endtask

  task automatic test_random();
    int a;
    for (int n = 0; n < 12; n++) begin
      a = 5 * $urandom_range(0, 819);
      build_model(a);
      run_request(a, 1);
      checks++;
      if (timedOut || seq_str(gotQ) != seq_str(expQ)) begin
        failures++;
        $display("FAIL rand_seq amount=%0d: got [%s], want [%s]", a, seq_str(gotQ), seq_str(expQ));
      end
      checks++;
      if (cnt_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rand_cnt amount=%0d: got %h, want %h", a, cnt_vec(), exp_vec());
      end
      checks++;
      if (holdBad != 0 || badGap != 0) begin
        failures++;
        $display("FAIL rand_protocol amount=%0d: hold_violations=%0d gap_violations=%0d, want 0 0",
                 a, holdBad, badGap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_185();
    test_1290();
    test_bad_amount();
    test_zero();
    test_stall();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
